// File: rtl/xnor_correlator.sv
// xnor_correlator
//   Serial-bit pattern correlator for sync-word detection. Data bits are shifted into a WIDTH-bit
//   window. The window is compared against a loaded pattern with a bitwise XNOR array, and the
//   number of matching bits is reported as the score. A one-cycle hit pulse fires on every shift
//   that completes a full window with score >= THRESH. Hit pulses are counted in a saturating
//   counter.
//
// Parameters
//   WIDTH   pattern / window length in bits (>= 2)
//   THRESH  minimum score for a hit (1..WIDTH)
//   CNT_W   hit counter width
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active high; overrides load and shift
//   i_load       capture i_pat (and i_mask) and restart the window fill
//   i_pat        pattern; i_pat[WIDTH-1] is compared with the oldest bit
//   i_mask       (XNOR_CORR_MASK_EN only) per-bit compare enable, captured on load
//   i_din_valid  shift i_din into the window on this edge
//   i_din        serial data bit
//   o_score      matching-bit count of the current window
//   o_hit        one-cycle pulse: full window with score >= THRESH
//   o_hit_cnt    saturating count of hit pulses
//
// Build option
//   XNOR_CORR_MASK_EN  adds i_mask. Masked-off bits always count as matches.
module xnor_correlator #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned THRESH = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic [WIDTH-1:0]           i_pat,
`ifdef XNOR_CORR_MASK_EN
    input  logic [WIDTH-1:0]           i_mask,
`endif
    input  logic                       i_din_valid,
    input  logic                       i_din,
    output logic [$clog2(WIDTH+1)-1:0] o_score,
    output logic                       o_hit,
    output logic [CNT_W-1:0]           o_hit_cnt
);

    localparam int unsigned SCORE_W = $clog2(WIDTH + 1);
    localparam logic [SCORE_W-1:0] FILL_MAX = SCORE_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_pat;
    logic [SCORE_W-1:0] r_fill;
    logic [SCORE_W-1:0] r_score;
    logic               r_hit;
    logic [CNT_W-1:0]   r_hit_cnt;

    logic [WIDTH-1:0]   w_sr_shift;
    logic [WIDTH-1:0]   w_care;
    logic [WIDTH-1:0]   w_match;
    logic [SCORE_W-1:0] w_popcount;
    logic [WIDTH-1:0]   w_sr_next;
    logic [SCORE_W-1:0] w_fill_next;
    logic [SCORE_W-1:0] w_score_next;
    logic               w_hit_next;

`ifdef XNOR_CORR_MASK_EN
    logic [WIDTH-1:0] r_mask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask <= '0;
        end else if (i_load) begin
            r_mask <= i_mask;
        end
    end

    assign w_care = r_mask;
`else
    assign w_care = '1;
`endif

    // Score is taken on the window as it will be after this shift, giving one-edge latency.
    assign w_sr_shift = {r_sr[WIDTH-2:0], i_din};
    assign w_match    = ~(w_sr_shift ^ r_pat) | ~w_care;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_popcount = w_popcount + SCORE_W'(w_match[i]);
        end
    end

    always_comb begin
        w_sr_next    = r_sr;
        w_fill_next  = r_fill;
        w_score_next = r_score;
        w_hit_next   = 1'b0;
        if (i_load) begin
            // Load wins over a concurrent shift; that bit is dropped.
            w_sr_next    = '0;
            w_fill_next  = '0;
            w_score_next = '0;
        end else if (i_din_valid) begin
            w_sr_next = w_sr_shift;
            if (r_fill != FILL_MAX) begin
                w_fill_next = r_fill + 1'b1;
            end
            w_score_next = w_popcount;
            w_hit_next   = (w_fill_next == FILL_MAX) && (32'(w_popcount) >= THRESH);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr      <= '0;
            r_pat     <= '0;
            r_fill    <= '0;
            r_score   <= '0;
            r_hit     <= 1'b0;
            r_hit_cnt <= '0;
        end else begin
            r_sr    <= w_sr_next;
            r_fill  <= w_fill_next;
            r_score <= w_score_next;
            r_hit   <= w_hit_next;
            if (i_load) begin
                r_pat <= i_pat;
            end
            if (w_hit_next && (r_hit_cnt != CNT_MAX)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

    assign o_score   = r_score;
    assign o_hit     = r_hit;
    assign o_hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_xnor_correlator.sv
// Testbench for xnor_correlator. Three instances share one stimulus stream:
//   dut_a  WIDTH=8 THRESH=8 CNT_W=16
//   dut_b  WIDTH=8 THRESH=7 CNT_W=16
//   dut_c  WIDTH=8 THRESH=8 CNT_W=4
module tb_xnor_correlator;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] pat;
    logic [7:0] mask;
    logic       vld;
    logic       din;

    logic [3:0]  a_score, b_score, c_score;
    logic        a_hit, b_hit, c_hit;
    logic [15:0] a_cnt, b_cnt;
    logic [3:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xnor_correlator #(.WIDTH(8), .THRESH(8), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_pat(pat),
`ifdef XNOR_CORR_MASK_EN
        .i_mask(mask),
`endif
        .i_din_valid(vld), .i_din(din),
        .o_score(a_score), .o_hit(a_hit), .o_hit_cnt(a_cnt)
    );

    xnor_correlator #(.WIDTH(8), .THRESH(7), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_pat(pat),
`ifdef XNOR_CORR_MASK_EN
        .i_mask(mask),
`endif
        .i_din_valid(vld), .i_din(din),
        .o_score(b_score), .o_hit(b_hit), .o_hit_cnt(b_cnt)
    );

    xnor_correlator #(.WIDTH(8), .THRESH(8), .CNT_W(4)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_pat(pat),
`ifdef XNOR_CORR_MASK_EN
        .i_mask(mask),
`endif
        .i_din_valid(vld), .i_din(din),
        .o_score(c_score), .o_hit(c_hit), .o_hit_cnt(c_cnt)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic [7:0] pat;
        logic       vld;
        logic       din;
        int         score;
        logic       hit;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic [7:0] p, input logic v,
                       input logic d, input int s, input logic h, input int c);
        vec_t e;
        e.rst = r; e.load = l; e.pat = p; e.vld = v; e.din = d;
        e.score = s; e.hit = h; e.cnt = c;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, clock one edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic l, input logic [7:0] p, input logic v,
                        input logic d);
        rst = r; load = l; pat = p; vld = v; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; pat = 8'h00; mask = 8'hFF; vld = 1'b0; din = 1'b0;

        // Test 1: exact pattern 1011_0010, scores hand-computed per partial window.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'hB2, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 3, 0, 0);
        add(0, 0, 8'h00, 1, 0, 5, 0, 0);
        add(0, 0, 8'h00, 1, 1, 2, 0, 0);
        add(0, 0, 8'h00, 1, 1, 3, 0, 0);
        add(0, 0, 8'h00, 1, 0, 5, 0, 0);
        add(0, 0, 8'h00, 1, 0, 3, 0, 0);
        add(0, 0, 8'h00, 1, 1, 2, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8, 1, 1);
        add(0, 0, 8'h00, 0, 0, 8, 0, 1);
        // Test 2: fill rule with PAT=FF, then overlapping hits.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 0, 8'h00, 1, 1, k, 0, 0);
        add(0, 0, 8'h00, 1, 1, 8, 1, 1);
        add(0, 0, 8'h00, 1, 1, 8, 1, 2);
        add(0, 0, 8'h00, 0, 1, 8, 0, 2);
        // Test 4: LOAD with a concurrent valid bit restarts fill; count survives; mid-stream reset.
        add(0, 1, 8'hFF, 0, 0, 0, 0, 2);
        for (int k = 1; k <= 5; k++) add(0, 0, 8'h00, 1, 1, k, 0, 2);
        add(0, 1, 8'hFF, 1, 1, 0, 0, 2);
        for (int k = 1; k <= 7; k++) add(0, 0, 8'h00, 1, 1, k, 0, 2);
        add(0, 0, 8'h00, 1, 1, 8, 1, 3);
        add(0, 0, 8'h00, 1, 1, 8, 1, 4);
        add(1, 1, 8'hFF, 1, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].pat, vecs[i].vld, vecs[i].din);
            check($sformatf("vec%0d score", i), int'(a_score), vecs[i].score);
            check($sformatf("vec%0d hit", i), int'(a_hit), int'(vecs[i].hit));
            check($sformatf("vec%0d hit_cnt", i), int'(a_cnt), vecs[i].cnt);
        end

        // Test 3: one mismatching bit; THRESH=7 hits, THRESH=8 does not.
        begin
            logic [7:0] s3;
            s3 = 8'b1011_0011;
            step(1, 0, 8'h00, 0, 0);
            step(0, 1, 8'hB2, 0, 0);
            for (int k = 7; k >= 0; k--) step(0, 0, 8'h00, 1, s3[k]);
            check("t3 score thresh8", int'(a_score), 7);
            check("t3 hit thresh8", int'(a_hit), 0);
            check("t3 score thresh7", int'(b_score), 7);
            check("t3 hit thresh7", int'(b_hit), 1);
            check("t3 cnt thresh7", int'(b_cnt), 1);
        end

        // Test 5: continuous ones saturate the 4-bit counter; gaps drop HIT.
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'hFF, 0, 0);
        for (int k = 1; k <= 28; k++) begin
            step(0, 0, 8'h00, 1, 1);
            check($sformatf("t5 c_cnt k%0d", k), int'(c_cnt), (k < 8) ? 0 : ((k - 7 > 15) ? 15 : k - 7));
            check($sformatf("t5 c_hit k%0d", k), int'(c_hit), (k >= 8) ? 1 : 0);
        end
        check("t5 a_cnt no saturation", int'(a_cnt), 21);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 8'h00, 0, 1);
            check($sformatf("t5 gap hit %0d", k), int'(c_hit), 0);
            check($sformatf("t5 gap score %0d", k), int'(c_score), 8);
            step(0, 0, 8'h00, 1, 1);
            check($sformatf("t5 post-gap hit %0d", k), int'(c_hit), 1);
            check($sformatf("t5 post-gap cnt %0d", k), int'(c_cnt), 15);
        end
        check("t5 a_cnt after gaps", int'(a_cnt), 25);

        // Test 6: mask 0F, stream 0,0,0,0,1,1,1,1 against PAT=FF.
        mask = 8'h0F;
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'hFF, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 8'h00, 1, (k >= 4) ? 1'b1 : 1'b0);
`ifdef XNOR_CORR_MASK_EN
        check("t6 masked score", int'(a_score), 8);
        check("t6 masked hit", int'(a_hit), 1);
`else
        check("t6 unmasked score", int'(a_score), 4);
        check("t6 unmasked hit", int'(a_hit), 0);
`endif
        mask = 8'hFF;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
